fp_addsub_seq: RTL and testbench

//  Parametrised IEEE-754 add/subtract engine. Successor to the fixed 32-bit adder controller.

---
 rtl/fp_addsub_seq_if.sv | 24 ++
 rtl/fp_addsub_seq.sv | 204 ++++++++++++++++++++
 tb/tb_fp_addsub_seq.sv | 118 +++++++++++
 3 files changed

// File: rtl/fp_addsub_seq_if.sv
// Request/result handshake bundle between the FPU op dispatcher, the add/sub engine
// and the writeback arbiter.
interface fp_addsub_seq_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
);
  localparam int W = 1 + EXP_W + MAN_W;

  logic [W-1:0] Datain1;
  logic [W-1:0] Datain2;
  logic         Op;
  logic [1:0]   Rmode;
  logic         Data_valid;
  logic         Data_ready;
  logic [W-1:0] Dataout;
  logic         Dataout_valid;
  logic         Dataout_ready;
  logic [3:0]   Exc;

  modport master (output Datain1, Datain2, Op, Rmode, Data_valid, Dataout_ready,
                  input  Data_ready, Dataout, Dataout_valid, Exc);
  modport slave  (input  Datain1, Datain2, Op, Rmode, Data_valid, Dataout_ready,
                  output Data_ready, Dataout, Dataout_valid, Exc);
endinterface

// File: rtl/fp_addsub_seq.sv
// Multi-cycle IEEE-754 add/subtract: IDLE -> ALIGN -> ADD -> NORM -> ROUND -> OUT,
// with G/R/S sticky rounding in four modes and valid/ready on both sides.
module fp_addsub_seq #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter bit FTZ   = 1'b0
) (
  input logic            CLK,
  input logic            RSTn,
  fp_addsub_seq_if.slave io
);
  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int M  = MAN_W + 1;     // significand incl. hidden bit
  localparam int X  = M + 3;         // significand + G/R/S
  localparam int EW = EXP_W + 1;     // exponent with headroom for overflow

  localparam logic [EXP_W-1:0] EMAX = '1;
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
  localparam logic [1:0] RNE = 2'b00, RTZ = 2'b01, RUP = 2'b10, RDN = 2'b11;

  typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_ADD, S_NORM, S_ROUND, S_OUT} state_t;
  state_t state;

  logic [W-1:0]  a_q, b_q, spec_res_q;
  logic [1:0]    rm_q;
  logic          sgn_q, sub_q, spec_q, spec_inv_q;
  logic [EW-1:0] exp_q;
  logic [X-1:0]  ma_q, mb_q, nrm_q;
  logic [X:0]    sum_q;

  // ---------------- ALIGN: unpack, order by magnitude, align ----------------
  logic             sa, sb, sl, ss, nan_a, nan_b, inf_a, inf_b, swap;
  logic [EXP_W-1:0] ea, eb, el, es, exl, exs, diff, sh;
  logic [MAN_W-1:0] fa, fb, fa_e, fb_e, fl, fs;
  logic [M-1:0]     sig_l, sig_s;
  logic [X-1:0]     mb_al, lost;
  logic             spec_d, inv_d;
  logic [W-1:0]     spec_res_d;

  assign {sa, ea, fa} = a_q;
  assign {sb, eb, fb} = b_q;

  always_comb begin
    fa_e  = (FTZ && ea == '0) ? '0 : fa;
    fb_e  = (FTZ && eb == '0) ? '0 : fb;
    nan_a = (ea == EMAX) && (fa != '0);
    nan_b = (eb == EMAX) && (fb != '0);
    inf_a = (ea == EMAX) && (fa == '0);
    inf_b = (eb == EMAX) && (fb == '0);
    swap  = {eb, fb_e} > {ea, fa_e};
    sl    = swap ? sb : sa;
    ss    = swap ? sa : sb;
    el    = swap ? eb : ea;
    es    = swap ? ea : eb;
    fl    = swap ? fb_e : fa_e;
    fs    = swap ? fa_e : fb_e;
    sig_l = {el != '0, fl};
    sig_s = {es != '0, fs};
    // subnormals sit at the same scale as exponent 1
    exl   = (el == '0) ? EXP_W'(1) : el;
    exs   = (es == '0) ? EXP_W'(1) : es;
    diff  = exl - exs;
    sh    = (diff > EXP_W'(X-1)) ? EXP_W'(X-1) : diff;
    {mb_al, lost} = {sig_s, 3'b000, {X{1'b0}}} >> sh;
    mb_al[0] = mb_al[0] | (|lost);

    spec_d = nan_a | nan_b | inf_a | inf_b;
    inv_d  = (nan_a && !fa[MAN_W-1]) || (nan_b && !fb[MAN_W-1]) ||
             (inf_a && inf_b && (sa ^ sb));
    if (nan_a || nan_b || (inf_a && inf_b && (sa ^ sb))) spec_res_d = QNAN;
    else if (inf_a) spec_res_d = {sa, EMAX, {MAN_W{1'b0}}};
    else            spec_res_d = {sb, EMAX, {MAN_W{1'b0}}};
  end

  // ---------------- ADD ----------------
  logic [X:0] sum_d;
  assign sum_d = sub_q ? ({1'b0, ma_q} - {1'b0, mb_q}) : ({1'b0, ma_q} + {1'b0, mb_q});

  // ---------------- NORM ----------------
  logic [EW-1:0] lz, lim, nsh, nexp_d;
  logic [X-1:0]  nrm_d;

  always_comb begin
    lz = EW'(X);
    for (int i = 0; i < X; i++) if (sum_q[i]) lz = EW'(X-1-i);
    lim = exp_q - EW'(1);
    nsh = (lz < lim) ? lz : lim;
    if (sum_q[X]) begin
      nrm_d  = {sum_q[X:2], sum_q[1] | sum_q[0]};
      nexp_d = exp_q + EW'(1);
    end else begin
      nrm_d  = sum_q[X-1:0] << nsh;
      nexp_d = exp_q - nsh;
    end
  end

  // ---------------- ROUND / pack ----------------
  logic [M-1:0]     mant, mant_f;
  logic [M:0]       mant_r;
  logic             g, r, s, grs, inc, tiny, zsign;
  logic [EW-1:0]    exp_f;
  logic [EXP_W-1:0] exp_enc;
  logic [W-1:0]     res_d;
  logic [3:0]       exc_d;

  always_comb begin
    {mant, g, r, s} = nrm_q;
    grs = g | r | s;
    case (rm_q)
      RNE:     inc = g & (r | s | mant[0]);
      RTZ:     inc = 1'b0;
      RUP:     inc = grs & ~sgn_q;
      default: inc = grs & sgn_q;
    endcase
    mant_r = {1'b0, mant} + {{M{1'b0}}, inc};
    if (mant_r[M]) begin
      mant_f = mant_r[M:1];
      exp_f  = exp_q + EW'(1);
    end else begin
      mant_f = mant_r[M-1:0];
      exp_f  = exp_q;
    end
    tiny    = ~mant_f[M-1];
    exp_enc = tiny ? '0 : exp_f[EXP_W-1:0];
    zsign   = sub_q ? (rm_q == RDN) : sgn_q;
    res_d   = {sgn_q, exp_enc, mant_f[MAN_W-1:0]};
    exc_d   = {2'b00, tiny & grs, grs};
    if (mant_f == '0) begin
      res_d = {zsign, {(W-1){1'b0}}};
    end else if (exp_f >= {1'b0, EMAX}) begin
      exc_d = 4'b0101;
      if (rm_q == RNE || (rm_q == RUP && !sgn_q) || (rm_q == RDN && sgn_q))
        res_d = {sgn_q, EMAX, {MAN_W{1'b0}}};
      else
        res_d = {sgn_q, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
    end else if (FTZ && tiny) begin
      res_d = {sgn_q, {(W-1){1'b0}}};
    end
    if (spec_q) begin
      res_d = spec_res_q;
      exc_d = {spec_inv_q, 3'b000};
    end
  end

  // ---------------- control ----------------
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state            <= S_IDLE;
      io.Data_ready    <= 1'b1;
      io.Dataout       <= '0;
      io.Dataout_valid <= 1'b0;
      io.Exc           <= '0;
      a_q <= '0; b_q <= '0; rm_q <= '0;
      sgn_q <= 1'b0; sub_q <= 1'b0; spec_q <= 1'b0; spec_inv_q <= 1'b0;
      spec_res_q <= '0; exp_q <= '0; ma_q <= '0; mb_q <= '0; sum_q <= '0; nrm_q <= '0;
    end else begin
      case (state)
        S_IDLE: if (io.Data_valid) begin
          a_q           <= io.Datain1;
          b_q           <= {io.Datain2[W-1] ^ io.Op, io.Datain2[W-2:0]};
          rm_q          <= io.Rmode;
          io.Data_ready <= 1'b0;
          state         <= S_ALIGN;
        end
        S_ALIGN: begin
          sgn_q      <= sl;
          sub_q      <= sl ^ ss;
          exp_q      <= {1'b0, exl};
          ma_q       <= {sig_l, 3'b000};
          mb_q       <= mb_al;
          spec_q     <= spec_d;
          spec_inv_q <= inv_d;
          spec_res_q <= spec_res_d;
          state      <= S_ADD;
        end
        S_ADD: begin
          sum_q <= sum_d;
          state <= S_NORM;
        end
        S_NORM: begin
          nrm_q <= nrm_d;
          exp_q <= nexp_d;
          state <= S_ROUND;
        end
        S_ROUND: begin
          io.Dataout <= res_d;
          io.Exc     <= exc_d;
          state      <= S_OUT;
        end
        S_OUT: begin
          // valid rises one cycle after the result lands, then holds until taken
          if (!io.Dataout_valid) io.Dataout_valid <= 1'b1;
          else if (io.Dataout_ready) begin
            io.Dataout_valid <= 1'b0;
            io.Data_ready    <= 1'b1;
            state            <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_addsub_seq.sv
// Directed single-precision vectors for fp_addsub_seq: results, flags, latency,
// output hold under backpressure and abort on reset.
module tb_fp_addsub_seq;
  localparam int EXP_W = 8;
  localparam int MAN_W = 23;

  logic CLK  = 1'b0;
  logic RSTn = 1'b0;
  always #5 CLK = ~CLK;

  fp_addsub_seq_if #(.EXP_W(EXP_W), .MAN_W(MAN_W)) io ();

  fp_addsub_seq #(.EXP_W(EXP_W), .MAN_W(MAN_W), .FTZ(1'b0)) dut (
    .CLK (CLK),
    .RSTn(RSTn),
    .io  (io)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One transaction: accept, scramble inputs, check 5-edge latency, result,
  // flags, optional backpressure hold, then hand-off back to IDLE.
  task automatic run(input string tag, input logic [31:0] a, input logic [31:0] b,
                     input logic op, input logic [1:0] rm,
                     input logic [31:0] er, input logic [3:0] ee, input int hold);
    int k;
    k = 0;
    while (io.Data_ready !== 1'b1 && k < 20) begin @(posedge CLK); #1; k++; end
    io.Datain1 = a; io.Datain2 = b; io.Op = op; io.Rmode = rm; io.Data_valid = 1'b1;
    @(posedge CLK); #1;
    io.Data_valid = 1'b0;
    io.Datain1 = 32'hDEADBEEF; io.Datain2 = 32'h12345678; io.Op = ~op; io.Rmode = ~rm;
    chk({tag, "/busy"}, 64'(io.Data_ready), 64'd0);
    k = 0;
    while (io.Dataout_valid !== 1'b1 && k < 20) begin @(posedge CLK); #1; k++; end
    chk({tag, "/lat"}, 64'(k), 64'd5);
    chk({tag, "/res"}, 64'(io.Dataout), 64'(er));
    chk({tag, "/exc"}, 64'(io.Exc), 64'(ee));
    for (int i = 0; i < hold; i++) begin
      @(posedge CLK); #1;
      chk({tag, "/hold"}, {26'd0, io.Dataout_valid, io.Data_ready, io.Exc, io.Dataout},
                          {26'd0, 1'b1, 1'b0, ee, er});
    end
    io.Dataout_ready = 1'b1;
    @(posedge CLK); #1;
    io.Dataout_ready = 1'b0;
    chk({tag, "/done"}, {62'd0, io.Dataout_valid, io.Data_ready}, {62'd0, 1'b0, 1'b1});
  endtask

  initial begin
    bit seen;
    io.Datain1 = '0; io.Datain2 = '0; io.Op = 1'b0; io.Rmode = 2'b00;
    io.Data_valid = 1'b0; io.Dataout_ready = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    chk("reset", {26'd0, io.Data_ready, io.Dataout_valid, io.Exc, io.Dataout},
                 {26'd0, 1'b1, 1'b0, 4'h0, 32'h0});
    @(negedge CLK) RSTn = 1'b1;

    //   tag          A             B             Op    Rmode  result        Exc   hold
    run("one+one",    32'h3F800000, 32'h3F800000, 1'b0, 2'b00, 32'h40000000, 4'h0, 0);
    run("1-1 rne",    32'h3F800000, 32'h3F800000, 1'b1, 2'b00, 32'h00000000, 4'h0, 0);
    run("1-1 rdn",    32'h3F800000, 32'h3F800000, 1'b1, 2'b11, 32'h80000000, 4'h0, 0);
    run("tie even",   32'h3F800000, 32'h33800000, 1'b0, 2'b00, 32'h3F800000, 4'h1, 0);
    run("tie rup",    32'h3F800000, 32'h33800000, 1'b0, 2'b10, 32'h3F800001, 4'h1, 0);
    run("tie odd",    32'h3F800001, 32'h33800000, 1'b0, 2'b00, 32'h3F800002, 4'h1, 0);
    run("gr rne",     32'h3F800000, 32'h33C00000, 1'b0, 2'b00, 32'h3F800001, 4'h1, 0);
    run("neg rdn",    32'hBF800000, 32'hB3800000, 1'b0, 2'b11, 32'hBF800001, 4'h1, 0);
    run("neg rup",    32'hBF800000, 32'hB3800000, 1'b0, 2'b10, 32'hBF800000, 4'h1, 0);
    run("sat rup",    32'h3F800000, 32'h00000001, 1'b0, 2'b10, 32'h3F800001, 4'h1, 0);
    run("sat rne",    32'h3F800000, 32'h00000001, 1'b0, 2'b00, 32'h3F800000, 4'h1, 0);
    run("ovf rne",    32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 2'b00, 32'h7F800000, 4'h5, 0);
    run("ovf rtz",    32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 2'b01, 32'h7F7FFFFF, 4'h5, 0);
    run("novf rup",   32'hFF7FFFFF, 32'hFF7FFFFF, 1'b0, 2'b10, 32'hFF7FFFFF, 4'h5, 0);
    run("inf-inf",    32'h7F800000, 32'h7F800000, 1'b1, 2'b00, 32'h7FC00000, 4'h8, 0);
    run("-inf+1",     32'hFF800000, 32'h3F800000, 1'b0, 2'b00, 32'hFF800000, 4'h0, 0);
    run("snan",       32'h7FA00000, 32'h3F800000, 1'b0, 2'b00, 32'h7FC00000, 4'h8, 0);
    run("qnan",       32'h7FC00000, 32'h3F800000, 1'b0, 2'b00, 32'h7FC00000, 4'h0, 0);
    run("3-1",        32'h40400000, 32'h3F800000, 1'b1, 2'b00, 32'h40000000, 4'h0, 0);
    run("cancel",     32'h3F800001, 32'h3F800000, 1'b1, 2'b00, 32'h34000000, 4'h0, 0);
    run("sub+sub",    32'h00000001, 32'h00000001, 1'b0, 2'b00, 32'h00000002, 4'h0, 0);
    run("minn-sub",   32'h00800000, 32'h00000001, 1'b1, 2'b00, 32'h007FFFFF, 4'h0, 0);
    run("stall",      32'h3F800000, 32'h3F800000, 1'b0, 2'b00, 32'h40000000, 4'h0, 10);

    // Abort: reset lands while the new op is in ALIGN.
    io.Datain1 = 32'h40400000; io.Datain2 = 32'h3F800000; io.Op = 1'b0; io.Rmode = 2'b00;
    io.Data_valid = 1'b1;
    @(posedge CLK); #1;
    io.Data_valid = 1'b0;
    #1 RSTn = 1'b0;
    #1;
    chk("abort", {26'd0, io.Data_ready, io.Dataout_valid, io.Exc, io.Dataout},
                 {26'd0, 1'b1, 1'b0, 4'h0, 32'h0});
    repeat (2) @(posedge CLK);
    @(negedge CLK) RSTn = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge CLK); #1;
      if (io.Dataout_valid !== 1'b0) seen = 1'b1;
    end
    chk("no stray valid", 64'(seen), 64'd0);
    chk("ready after abort", 64'(io.Data_ready), 64'd1);
    run("recover",    32'h3F800000, 32'h3F800000, 1'b0, 2'b00, 32'h40000000, 4'h0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
